// File: rtl/pipe_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg
//   Shared definitions for the elastic inter-stage pipeline register
//   (pipe_stage_reg) and its storage element (pipe_entry).
//   - occ_e          : stage occupancy encoding (also used as FSM state)
//   - CTRL_BUBBLE    : all-zero control word, meaning "no side effect"
//   - *_W_DEF        : default payload widths
//   - EXMEM_*        : bit offsets of the EX/MEM control fields
//   - occ_from_valid : maps the two entry valid bits to an occupancy
// ---------------------------------------------------------------------------
package pipe_pkg;

   localparam int CTRL_W_DEF = 16;
   localparam int DATA_W_DEF = 128;

   typedef enum logic [1:0] {
      OCC_EMPTY = 2'd0,
      OCC_ONE   = 2'd1,
      OCC_FULL  = 2'd2
   } occ_e;

   localparam logic [CTRL_W_DEF-1:0] CTRL_BUBBLE = '0;

   // EX/MEM control word layout (LSB offsets, widths in comments)
   localparam int EXMEM_REGWR    = 0;   // 1 bit
   localparam int EXMEM_MEMRD    = 1;   // 1 bit
   localparam int EXMEM_MEMWR    = 2;   // 1 bit
   localparam int EXMEM_MEMTOREG = 3;   // 2 bits [4:3]
   localparam int EXMEM_PCSRC    = 5;   // 3 bits [7:5]
   localparam int EXMEM_ADDRC    = 8;   // 5 bits [12:8]

   // The skid entry is only ever valid when main is valid, so the skid
   // bit alone identifies the full state.
   function automatic occ_e occ_from_valid(input logic main_v, input logic skid_v);
      if (skid_v)
         return OCC_FULL;
      else if (main_v)
         return OCC_ONE;
      return OCC_EMPTY;
   endfunction

endpackage

// File: rtl/pipe_entry.sv
// ---------------------------------------------------------------------------
// pipe_entry
//   One storage slot of the pipeline register: valid + ctrl + data.
//   Ports:
//     clk      in   rising-edge clock
//     reset    in   asynchronous, active-low; clears valid, ctrl and data
//     load     in   capture ld_ctrl/ld_data and mark valid
//     clr      in   invalidate and zero ctrl (data held); wins over load
//     ld_ctrl  in   control word to capture
//     ld_data  in   data word to capture
//     valid    out  slot holds an entry
//     ctrl     out  held control (zero whenever valid=0)
//     data     out  held data
// ---------------------------------------------------------------------------
module pipe_entry
   import pipe_pkg::*;
#(
   parameter int CTRL_W = CTRL_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic              clr,
   input  logic [CTRL_W-1:0] ld_ctrl,
   input  logic [DATA_W-1:0] ld_data,
   output logic              valid,
   output logic [CTRL_W-1:0] ctrl,
   output logic [DATA_W-1:0] data
);

   logic              valid_d, valid_q;
   logic [CTRL_W-1:0] ctrl_d,  ctrl_q;
   logic [DATA_W-1:0] data_d,  data_q;

   // Data only changes on load, so its enable is a clean clock-gating term.
   always_comb begin
      valid_d = valid_q;
      ctrl_d  = ctrl_q;
      data_d  = data_q;
      if (clr) begin
         valid_d = 1'b0;
         ctrl_d  = '0;
      end else if (load) begin
         valid_d = 1'b1;
         ctrl_d  = ld_ctrl;
         data_d  = ld_data;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid_q <= 1'b0;
         ctrl_q  <= '0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         ctrl_q  <= ctrl_d;
         data_q  <= data_d;
      end
   end

   assign valid = valid_q;
   assign ctrl  = ctrl_q;
   assign data  = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg
//   Elastic inter-stage pipeline register (ID/EX, EX/MEM, MEM/WB) with a
//   two-entry skid buffer, stall, flush and zero-control bubbles.
//   All outputs come straight from flops; in_ready is ~skid_valid.
//   Optional: define PIPE_PERF_CNT_EN to add saturating stall/bubble
//   counters (cleared only by reset).
//   Ports:
//     clk        in   rising-edge clock
//     reset      in   asynchronous, active-low
//     flush      in   synchronous kill of all held entries
//     in_valid   in   upstream entry valid
//     in_ready   out  stage can accept (registered)
//     in_ctrl    in   upstream control word
//     in_data    in   upstream data word
//     out_valid  out  head entry valid
//     out_ready  in   downstream accepts head
//     out_ctrl   out  head control (zero when out_valid=0)
//     out_data   out  head data
//     occupancy  out  entries held, 0..2
//     stall_cnt  out  cycles with out_valid & ~out_ready (PIPE_PERF_CNT_EN)
//     bubble_cnt out  cycles with ~out_valid (PIPE_PERF_CNT_EN)
// ---------------------------------------------------------------------------
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int CTRL_W = CTRL_W_DEF,
   parameter int DATA_W = DATA_W_DEF,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        occupancy
`ifdef PIPE_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  bubble_cnt
`endif
);

   if (CNT_W < 1) begin : g_cnt_w_chk
      $error("pipe_stage_reg: CNT_W must be at least 1");
   end

   logic              main_valid, skid_valid;
   logic [CTRL_W-1:0] main_ctrl,  skid_ctrl;
   logic [DATA_W-1:0] main_data,  skid_data;

   logic              acc, drn;
   logic              main_load, main_from_skid, main_clr;
   logic              skid_load, skid_clr;
   logic [CTRL_W-1:0] main_ld_ctrl;
   logic [DATA_W-1:0] main_ld_data;
   occ_e              state;

   // The state register is the pair of entry valid bits.
   assign state = occ_from_valid(main_valid, skid_valid);

   assign acc = in_valid & ~skid_valid;
   assign drn = main_valid & out_ready;

   always_comb begin
      main_load      = 1'b0;
      main_from_skid = 1'b0;
      main_clr       = 1'b0;
      skid_load      = 1'b0;
      skid_clr       = 1'b0;
      if (flush) begin
         // Flush beats any simultaneous accept or drain.
         main_clr = 1'b1;
         skid_clr = 1'b1;
      end else begin
         unique case (state)
            OCC_EMPTY: begin
               main_load = acc;
            end
            OCC_ONE: begin
               if (acc && drn)
                  main_load = 1'b1;
               else if (acc)
                  skid_load = 1'b1;
               else if (drn)
                  main_clr = 1'b1;
            end
            OCC_FULL: begin
               // in_ready is low here, so only a drain can happen.
               if (drn) begin
                  main_load      = 1'b1;
                  main_from_skid = 1'b1;
                  skid_clr       = 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign main_ld_ctrl = main_from_skid ? skid_ctrl : in_ctrl;
   assign main_ld_data = main_from_skid ? skid_data : in_data;

   pipe_entry #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
      .clk     (clk),
      .reset   (reset),
      .load    (main_load),
      .clr     (main_clr),
      .ld_ctrl (main_ld_ctrl),
      .ld_data (main_ld_data),
      .valid   (main_valid),
      .ctrl    (main_ctrl),
      .data    (main_data)
   );

   pipe_entry #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
      .clk     (clk),
      .reset   (reset),
      .load    (skid_load),
      .clr     (skid_clr),
      .ld_ctrl (in_ctrl),
      .ld_data (in_data),
      .valid   (skid_valid),
      .ctrl    (skid_ctrl),
      .data    (skid_data)
   );

   assign in_ready  = ~skid_valid;
   assign out_valid = main_valid;
   assign out_ctrl  = main_ctrl;
   assign out_data  = main_data;
   assign occupancy = state;

`ifdef PIPE_PERF_CNT_EN
   logic [CNT_W-1:0] stall_cnt_d,  stall_cnt_q;
   logic [CNT_W-1:0] bubble_cnt_d, bubble_cnt_q;

   // Both counters saturate at all-ones; flush does not touch them.
   always_comb begin
      stall_cnt_d  = stall_cnt_q;
      bubble_cnt_d = bubble_cnt_q;
      if (main_valid && !out_ready && !(&stall_cnt_q))
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      if (!main_valid && !(&bubble_cnt_q))
         bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_cnt_q  <= '0;
         bubble_cnt_q <= '0;
      end else begin
         stall_cnt_q  <= stall_cnt_d;
         bubble_cnt_q <= bubble_cnt_d;
      end
   end

   assign stall_cnt  = stall_cnt_q;
   assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;

   typedef struct packed {
      logic [15:0]  c;
      logic [127:0] d;
   } ent_t;

   logic         clk;
   logic         reset;
   logic         flush;
   logic         in_valid;
   logic         in_ready;
   logic [15:0]  in_ctrl;
   logic [127:0] in_data;
   logic         out_valid;
   logic         out_ready;
   logic [15:0]  out_ctrl;
   logic [127:0] out_data;
   logic [1:0]   occupancy;

   int n_checks = 0;
   int n_fail   = 0;
   ent_t sb[$];

`ifdef PIPE_PERF_CNT_EN
   logic [15:0]  stall_cnt, bubble_cnt;
   logic [15:0]  exp_stall, exp_bubble;
   logic         in_ready2, out_valid2;
   logic [15:0]  out_ctrl2;
   logic [127:0] out_data2;
   logic [1:0]   occupancy2;
   logic [1:0]   stall_cnt2, bubble_cnt2;
   logic [1:0]   exp_stall2, exp_bubble2;
`endif

   pipe_stage_reg dut (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_ctrl   (in_ctrl),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_ctrl  (out_ctrl),
      .out_data  (out_data),
      .occupancy (occupancy)
`ifdef PIPE_PERF_CNT_EN
      ,
      .stall_cnt (stall_cnt),
      .bubble_cnt(bubble_cnt)
`endif
   );

`ifdef PIPE_PERF_CNT_EN
   pipe_stage_reg #(.CNT_W(2)) dut2 (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready2),
      .in_ctrl   (in_ctrl),
      .in_data   (in_data),
      .out_valid (out_valid2),
      .out_ready (out_ready),
      .out_ctrl  (out_ctrl2),
      .out_data  (out_data2),
      .occupancy (occupancy2),
      .stall_cnt (stall_cnt2),
      .bubble_cnt(bubble_cnt2)
   );
`endif

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish, got running, want finished");
      $fatal(1, "timeout");
   end

   task automatic clear_model();
      sb.delete();
`ifdef PIPE_PERF_CNT_EN
      exp_stall   = '0;
      exp_bubble  = '0;
      exp_stall2  = '0;
      exp_bubble2 = '0;
`endif
   endtask

   // Called at a negedge with inputs already driven; returns at the next negedge.
   task automatic cycle();
      logic acc, drn, vld_obs;
      logic [15:0]  c_obs;
      logic [127:0] d_obs;
      ent_t e;
      acc     = in_valid & in_ready;
      drn     = out_valid & out_ready;
      vld_obs = out_valid;
      c_obs   = out_ctrl;
      d_obs   = out_data;
      @(posedge clk);
      #1;
      if (flush) begin
         sb.delete();
      end else begin
         if (drn) begin
            n_checks++;
            if (sb.size() == 0) begin
               n_fail++;
               $display("FAIL drain_underflow: got drained data %0h, want no entry", d_obs);
            end else begin
               e = sb.pop_front();
               if ({c_obs, d_obs} !== {e.c, e.d}) begin
                  n_fail++;
                  $display("FAIL drain_order: got ctrl %h data %0h, want ctrl %h data %0h",
                           c_obs, d_obs, e.c, e.d);
               end
            end
         end
         if (acc) begin
            e.c = in_ctrl;
            e.d = in_data;
            sb.push_back(e);
         end
      end
`ifdef PIPE_PERF_CNT_EN
      if (vld_obs && !out_ready) begin
         if (exp_stall  != '1) exp_stall++;
         if (exp_stall2 != '1) exp_stall2++;
      end
      if (!vld_obs) begin
         if (exp_bubble  != '1) exp_bubble++;
         if (exp_bubble2 != '1) exp_bubble2++;
      end
      n_checks++;
      if (stall_cnt !== exp_stall || bubble_cnt !== exp_bubble) begin
         n_fail++;
         $display("FAIL perf_cnt: got stall %0d bubble %0d, want stall %0d bubble %0d",
                  stall_cnt, bubble_cnt, exp_stall, exp_bubble);
      end
      n_checks++;
      if (stall_cnt2 !== exp_stall2 || bubble_cnt2 !== exp_bubble2) begin
         n_fail++;
         $display("FAIL perf_cnt_w2: got stall %0d bubble %0d, want stall %0d bubble %0d",
                  stall_cnt2, bubble_cnt2, exp_stall2, exp_bubble2);
      end
`endif
      n_checks++;
      if (occupancy !== 2'(sb.size())) begin
         n_fail++;
         $display("FAIL occupancy: got %0d, want %0d", occupancy, sb.size());
      end
      n_checks++;
      if (out_valid !== (sb.size() != 0)) begin
         n_fail++;
         $display("FAIL out_valid: got %b, want %b", out_valid, sb.size() != 0);
      end
      n_checks++;
      if (in_ready !== (sb.size() < 2)) begin
         n_fail++;
         $display("FAIL in_ready: got %b, want %b", in_ready, sb.size() < 2);
      end
      n_checks++;
      if (sb.size() != 0) begin
         if (out_ctrl !== sb[0].c || out_data !== sb[0].d) begin
            n_fail++;
            $display("FAIL head: got ctrl %h data %0h, want ctrl %h data %0h",
                     out_ctrl, out_data, sb[0].c, sb[0].d);
         end
      end else if (out_ctrl !== 16'h0) begin
         n_fail++;
         $display("FAIL bubble_ctrl: got %h, want 0000", out_ctrl);
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      reset     = 1'b0;
      flush     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      in_ctrl   = '0;
      in_data   = '0;
      clear_model();
      repeat (2) @(negedge clk);
      reset = 1'b1;
      n_checks++;
      if (out_valid !== 1'b0 || out_ctrl !== 16'h0 || out_data !== 128'h0 ||
          in_ready !== 1'b1 || occupancy !== 2'd0) begin
         n_fail++;
         $display("FAIL reset_state: got v%b c%h d%0h r%b o%0d, want v0 c0000 d0 r1 o0",
                  out_valid, out_ctrl, out_data, in_ready, occupancy);
      end
      repeat (2) cycle();
   endtask

   task automatic test_stream();
      out_ready = 1'b1;
      in_ctrl   = 16'h00A5;
      for (int i = 1; i <= 8; i++) begin
         in_valid = 1'b1;
         in_data  = 128'(i);
         cycle();
         n_checks++;
         if (out_valid !== 1'b1 || out_data !== 128'(i) || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL stream: got v%b d%0d r%b, want v1 d%0d r1",
                     out_valid, out_data, in_ready, i);
         end
      end
      in_valid = 1'b0;
      repeat (2) cycle();
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_ctrl   = 16'h1234;
      in_data   = 128'd10;
      cycle();
      in_data   = 128'd11;
      cycle();
      in_valid  = 1'b0;
      in_data   = 128'hDEAD;
      n_checks++;
      if (occupancy !== 2'd2 || in_ready !== 1'b0 || out_data !== 128'd10) begin
         n_fail++;
         $display("FAIL backpressure_full: got o%0d r%b d%0d, want o2 r0 d10",
                  occupancy, in_ready, out_data);
      end
      cycle();
      out_ready = 1'b1;
      repeat (3) cycle();
      n_checks++;
      if (out_valid !== 1'b0 || out_ctrl !== 16'h0) begin
         n_fail++;
         $display("FAIL backpressure_empty: got v%b c%h, want v0 c0000", out_valid, out_ctrl);
      end
   endtask

   task automatic test_flush();
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_ctrl   = 16'h0F0F;
      in_data   = 128'd12;
      cycle();
      in_data   = 128'd13;
      cycle();
      flush     = 1'b1;
      out_ready = 1'b1;
      in_data   = 128'd20;
      cycle();
      flush     = 1'b0;
      in_valid  = 1'b0;
      n_checks++;
      if (out_valid !== 1'b0 || out_ctrl !== 16'h0 || occupancy !== 2'd0 ||
          out_data !== 128'd12) begin
         n_fail++;
         $display("FAIL flush_full: got v%b c%h o%0d d%0d, want v0 c0000 o0 d12",
                  out_valid, out_ctrl, occupancy, out_data);
      end
      repeat (2) cycle();
      // Flush at occupancy 1 while an accept is possible: the input is dropped.
      in_valid = 1'b1;
      in_data  = 128'd30;
      cycle();
      in_data  = 128'd20;
      flush    = 1'b1;
      cycle();
      flush    = 1'b0;
      in_valid = 1'b0;
      n_checks++;
      if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
         n_fail++;
         $display("FAIL flush_accept: got v%b o%0d, want v0 o0", out_valid, occupancy);
      end
      repeat (2) cycle();
   endtask

   task automatic test_idle_payload();
      out_ready = 1'b1;
      in_valid  = 1'b0;
      in_ctrl   = 16'hFFFF;
      in_data   = {4{32'hCAFEF00D}};
      repeat (3) cycle();
      n_checks++;
      if (out_valid !== 1'b0 || out_ctrl !== 16'h0 || occupancy !== 2'd0) begin
         n_fail++;
         $display("FAIL idle_ignored: got v%b c%h o%0d, want v0 c0000 o0",
                  out_valid, out_ctrl, occupancy);
      end
   endtask

   task automatic test_async_reset();
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_ctrl   = 16'h5A5A;
      in_data   = 128'd40;
      cycle();
      in_data   = 128'd41;
      cycle();
      in_valid  = 1'b0;
      #2;
      reset = 1'b0;
      #1;
      n_checks++;
      if (out_valid !== 1'b0 || out_ctrl !== 16'h0 || out_data !== 128'h0 ||
          in_ready !== 1'b1 || occupancy !== 2'd0) begin
         n_fail++;
         $display("FAIL async_reset: got v%b c%h d%0h r%b o%0d, want v0 c0000 d0 r1 o0",
                  out_valid, out_ctrl, out_data, in_ready, occupancy);
      end
      clear_model();
      @(negedge clk);
      reset = 1'b1;
      cycle();
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 300; i++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         flush     = ($urandom_range(0, 24) == 0);
         in_ctrl   = 16'($urandom);
         in_data   = {$urandom, $urandom, $urandom, $urandom};
         cycle();
      end
      flush     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (3) cycle();
   endtask

`ifdef PIPE_PERF_CNT_EN
   task automatic test_perf();
      flush     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      reset     = 1'b0;
      clear_model();
      @(negedge clk);
      reset     = 1'b1;
      in_valid  = 1'b1;
      in_ctrl   = 16'h0001;
      in_data   = 128'd50;
      cycle();
      in_valid  = 1'b0;
      repeat (5) cycle();
      n_checks++;
      if (stall_cnt !== 16'd5 || stall_cnt2 !== 2'd3) begin
         n_fail++;
         $display("FAIL perf_stall: got %0d and %0d, want 5 and 3", stall_cnt, stall_cnt2);
      end
      out_ready = 1'b1;
      cycle();
      repeat (3) cycle();
      n_checks++;
      if (bubble_cnt !== 16'd4 || stall_cnt !== 16'd5) begin
         n_fail++;
         $display("FAIL perf_bubble: got bubble %0d stall %0d, want bubble 4 stall 5",
                  bubble_cnt, stall_cnt);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_flush();
      test_idle_payload();
      test_async_reset();
      test_back_to_back();
`ifdef PIPE_PERF_CNT_EN
      test_perf();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
